// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Display payload held in both the pending and the active register sets
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  en;
        logic [3:0]  dp;
    } disp_cfg_t;

    // Active-low gfedcba patterns, entry 0 in the least-significant slot
    localparam logic [15:0][6:0] HEX7SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex-digit to active-low {dp,g,f,e,d,c,b,a} segment pattern.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = {~dp, HEX7SEG_TABLE[digit]};
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with inter-digit blanking and
// frame-aligned double buffering of the displayed value.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] disp_value,
    input  logic [3:0]  disp_en,
    input  logic [3:0]  disp_dp,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    disp_cfg_t        act_q, act_d;
    disp_cfg_t        pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_done_q, frame_done_d;

    logic [3:0]       mux_hex;
    logic             mux_dp;
    logic [7:0]       dec_seg_c;
    logic             slot_end;
    logic             frame_end;
    disp_cfg_t        load_cfg;

    // Select the nibble and decimal point of the digit currently being scanned
    always_comb begin
        mux_hex = act_q.value[{digit_q, 2'b00} +: 4];
        mux_dp  = act_q.dp[digit_q];
    end

    hex7seg_decode u_decode (
        .digit (mux_hex),
        .dp    (mux_dp),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        slot_end  = (state_q == DRIVE) && (cnt_q == CNT_LAST);
        frame_end = slot_end && (digit_q == 2'd3);
        load_cfg  = '{value: disp_value, en: disp_en, dp: disp_dp};

        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        digit_d      = digit_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        frame_done_d = frame_end;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                seg_d = dec_seg_c;
                if (act_q.en[digit_q]) begin
                    an_d[digit_q] = 1'b0;
                end
                if (slot_end) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase

        // A load on the frame boundary itself bypasses the pending buffer
        if (frame_end) begin
            if (load) begin
                act_d = load_cfg;
            end else if (pend_v_q) begin
                act_d = pend_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d   = load_cfg;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule
